// File: rtl/cookie_frame_reader.sv
// Reads one frame out of a cell grid's serial display chain and hands it to a consumer row by row.
// Optional COOKIE_FRAME_POPCOUNT_EN adds a live-cell counter output pop_count.
module cookie_frame_reader #(
  parameter  int GRID_W = 16,
  parameter  int GRID_H = 16,
  localparam int IW     = (GRID_H > 1) ? $clog2(GRID_H) : 1,
  localparam int CW     = $clog2(GRID_W + 1),
  localparam int PW     = $clog2(GRID_W * GRID_H + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              disp_load,
  output logic              disp_shift_en,
  input  logic              disp_bit_in,
  output logic [GRID_W-1:0] row_data,
  output logic [IW-1:0]     row_idx,
  output logic              row_valid,
  input  logic              row_ready,
  output logic              busy,
  output logic              frame_done
`ifdef COOKIE_FRAME_POPCOUNT_EN
  ,
  output logic [PW-1:0]     pop_count
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, HOLD, DONE} state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      disp_load     <= 1'b0;
      disp_shift_en <= 1'b0;
      row_data      <= '0;
      row_idx       <= '0;
      row_valid     <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      bit_cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= LOAD;
          disp_load <= 1'b1;
          busy      <= 1'b1;
          row_idx   <= IW'(GRID_H - 1);
          bit_cnt   <= '0;
        end
        LOAD: begin
          // snapshot happens on this edge; shifting starts next cycle
          disp_load     <= 1'b0;
          disp_shift_en <= 1'b1;
          bit_cnt       <= '0;
          state         <= SHIFT;
        end
        SHIFT: begin
          row_data <= {row_data[GRID_W-2:0], disp_bit_in};
          if (bit_cnt == CW'(GRID_W - 1)) begin
            disp_shift_en <= 1'b0;
            row_valid     <= 1'b1;
            state         <= HOLD;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        HOLD: if (row_ready) begin
          row_valid <= 1'b0;
          if (row_idx == '0) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            row_idx       <= row_idx - 1'b1;
            bit_cnt       <= '0;
            disp_shift_en <= 1'b1;
            state         <= SHIFT;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COOKIE_FRAME_POPCOUNT_EN
  // cleared on entry to LOAD, counts every sampled live bit, holds after the frame
  always_ff @(posedge clk) begin
    if (rst)
      pop_count <= '0;
    else if (state == IDLE && start)
      pop_count <= '0;
    else if (state == SHIFT && disp_bit_in)
      pop_count <= pop_count + 1'b1;
  end
`endif

endmodule
